// File: rtl/riscv_ctrl_redirect.sv
// PC redirect / front-end flush sequencer for taken branches and jumps resolved in execute.
// Optional feature: define RISCV_REDIRECT_PERFCNT_EN to build the accepted-redirect counter.
//
// state | meaning
// IDLE  | waiting for a taken branch/jump from execute
// REQ   | redirect offered to fetch, flush asserted
// DRAIN | redirect accepted, flush held while old-path fetch responses drain

module riscv_ctrl_redirect #(
   parameter int XLEN         = 32,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic            iclk,
   input  logic            irst,
   input  logic            iex_valid,
   input  logic            iex_take,
   input  logic [XLEN-1:0] iex_target,
   input  logic            ifetch_ready,
   output logic            oredirect_valid,
   output logic [XLEN-1:0] oredirect_pc,
   output logic            oflush,
   output logic            omisalign,
   output logic [31:0]     oredir_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // The DRAIN entry value is only used when FLUSH_CYCLES is non-zero.
   localparam logic [3:0] DRAIN_LOAD = (FLUSH_CYCLES == 0) ? 4'd0 : 4'(FLUSH_CYCLES - 1);

   state_t          state_q;
   state_t          state_d;
   logic [XLEN-1:0] pc_q;
   logic [3:0]      drain_q;
   logic            misalign_q;
   logic            br_event;
   logic            tgt_aligned;
   logic            handshake;

   assign br_event    = (state_q == IDLE) && iex_valid && iex_take;
   assign tgt_aligned = (iex_target[1:0] == 2'b00);
   assign handshake   = (state_q == REQ) && ifetch_ready;

   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (br_event && tgt_aligned) begin
               state_d = REQ;
            end
         end
         REQ: begin
            if (ifetch_ready) begin
               state_d = (FLUSH_CYCLES == 0) ? IDLE : DRAIN;
            end
         end
         DRAIN: begin
            if (drain_q == 4'd0) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      oredirect_valid = 1'b0;
      oflush          = 1'b0;
      case (state_q)
         REQ: begin
            oredirect_valid = 1'b1;
            oflush          = 1'b1;
         end
         DRAIN: oflush = 1'b1;
         default: begin
            oredirect_valid = 1'b0;
            oflush          = 1'b0;
         end
      endcase
   end

   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         pc_q       <= '0;
         drain_q    <= 4'd0;
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= br_event && !tgt_aligned;
         if (br_event && tgt_aligned) begin
            pc_q <= iex_target;
         end
         if (handshake) begin
            drain_q <= DRAIN_LOAD;
         end else if ((state_q == DRAIN) && (drain_q != 4'd0)) begin
            drain_q <= drain_q - 4'd1;
         end
      end
   end

   assign oredirect_pc = pc_q;
   assign omisalign    = misalign_q;

`ifdef RISCV_REDIRECT_PERFCNT_EN
   logic [31:0] redir_count_q;

   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         redir_count_q <= 32'd0;
      end else if (handshake) begin
         redir_count_q <= redir_count_q + 32'd1;
      end
   end

   assign oredir_count = redir_count_q;
`else
   assign oredir_count = 32'd0;
`endif

endmodule
